// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and helpers for the 4x4 keypad scanner.
//   kp_state_t  : scanner FSM state encoding
//   KP_N        : keypad dimension (rows == columns == 4)
//   key_map     : (row, col) -> hex code printed on the keypad
//   single_low  : detects exactly one low bit in an active-low row vector
package keypad_pkg;

    localparam int KP_N = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    // Keypad legend, row-major:
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E 0 F D
    function automatic logic [3:0] key_map(input logic [1:0] row_idx,
                                           input logic [1:0] col_idx);
        logic [3:0] code;
        case ({row_idx, col_idx})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Returns {hit, idx}: hit is set only when exactly one row is low,
    // idx is the index of that row. Multiple lows are ambiguous (ghosting
    // or a chord) and are rejected.
    function automatic logic [2:0] single_low(input logic [3:0] r);
        logic [1:0] idx;
        int         n;
        idx = 2'd0;
        n   = 0;
        for (int i = 0; i < KP_N; i++) begin
            if (!r[i]) begin
                n   = n + 1;
                idx = i[1:0];
            end
        end
        return {(n == 1), idx};
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync
// Two-flop synchroniser for the asynchronous keypad row lines.
//   clk   in  1  sampling clock
//   reset in  1  synchronous, active-high; output returns to all-ones (idle rows)
//   d     in  W  asynchronous input
//   q     out W  synchronised output, two cycles of latency
module keypad_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad, debounces press and release, and
// emits one key_valid strobe per accepted press with its hex code on key.
//   int_osc     in  1  clock
//   reset       in  1  synchronous, active-high
//   rows        in  4  keypad rows, active-low, asynchronous
//   cols        out 4  keypad columns, active-low, exactly one low
//   key         out 4  hex code of the last accepted key (held between presses)
//   key_valid   out 1  one-cycle strobe when a new press is accepted
//   key_held    out 1  high from acceptance until the release is debounced
//   debug_state out 2  current FSM state
//
// Handshake: key_valid is a pure strobe with no ready; key is valid in the
// cycle key_valid is high and stays stable until the next accepted press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 48000,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input  logic      int_osc,
    input  logic      reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic      key_valid,
    output logic      key_held,
    output kp_state_t debug_state
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_TOP   = DW'(DEBOUNCE_CYCLES);

    logic [3:0]    rows_s;
    kp_state_t     state;
    logic [1:0]    col_idx;
    logic [1:0]    row_lat;
    logic [SW-1:0] scan_cnt;
    logic [DW-1:0] deb_cnt;
    logic [2:0]    hit;
    logic          lat_high;

    keypad_sync #(.W(KP_N)) u_sync (
        .clk   (int_osc),
        .reset (reset),
        .d     (rows),
        .q     (rows_s)
    );

    assign hit         = single_low(rows_s);
    assign lat_high    = rows_s[row_lat];
    // col_idx only moves in SCAN, so the driven column is frozen in every
    // other state without extra logic.
    assign cols        = ~(4'b0001 << col_idx);
    assign debug_state = state;

    always_ff @(posedge int_osc) begin
        if (reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_lat   <= 2'd0;
            scan_cnt  <= '0;
            deb_cnt   <= '0;
            key       <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (scan_cnt == SCAN_LAST) begin
                        // Last dwell cycle: the synchronised rows have had
                        // time to settle for this column.
                        scan_cnt <= '0;
                        if (hit[2]) begin
                            row_lat <= hit[1:0];
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                        end
                    end else begin
                        scan_cnt <= scan_cnt + SW'(1);
                    end
                end

                DEBOUNCE: begin
                    if (lat_high) begin
                        // Bounce or too-short press: abandon, move on.
                        deb_cnt  <= '0;
                        scan_cnt <= '0;
                        col_idx  <= col_idx + 2'd1;
                        state    <= SCAN;
                    end else if (deb_cnt == DEB_TOP) begin
                        deb_cnt   <= '0;
                        key       <= key_map(row_lat, col_idx);
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        state     <= HELD;
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end

                HELD: begin
                    if (lat_high) begin
                        deb_cnt <= '0;
                        state   <= RELEASE;
                    end
                end

                RELEASE: begin
                    if (!lat_high) begin
                        // Release bounce: back to HELD without a new strobe.
                        deb_cnt <= '0;
                        state   <= HELD;
                    end else if (deb_cnt == DEB_TOP) begin
                        deb_cnt  <= '0;
                        scan_cnt <= '0;
                        key_held <= 1'b0;
                        col_idx  <= col_idx + 2'd1;
                        state    <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end

                default: state <= SCAN;
            endcase
        end
    end

endmodule
